seq_pattern_counter: RTL

Streaming successor to the combinational 32-bit "101" counter. Accepts a serial bit stream one bit per valid cycle and counts occurrences of a runtime-programmable PAT_W-bit pattern over a frame of FRAME_LEN bits, in overlapping or non-overlapping mode. At frame end it presents a saturating count with a one-cycle valid strobe. Sits between a serial front end (deserialiser or LFSR source) and a status/CSR collector.

---
 rtl/seq_pattern_pkg.sv | 11 +
 rtl/seq_pattern_counter_if.sv | 34 +++
 rtl/pattern_window.sv | 56 +++++
 rtl/seq_pattern_counter.sv | 65 ++++++
 4 files changed

// File: rtl/seq_pattern_pkg.sv
// seq_pattern_pkg: shared state codes, count-mode constants and counter width helper.
package seq_pattern_pkg;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic MODE_NONOVL = 1'b0;
    localparam logic MODE_OVL    = 1'b1;
    function automatic int ctr_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/seq_pattern_counter_if.sv
// seq_pattern_counter_if: stream/control/status bundle of the pattern counter.
// SEQ_PAT_MASK_EN adds the pat_mask don't-care input.
interface seq_pattern_counter_if #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 6
);
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic             overlap;
    logic             bit_in;
    logic             bit_valid;
    logic             busy;
    logic             match;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             count_valid;
`ifdef SEQ_PAT_MASK_EN
    logic [PAT_W-1:0] pat_mask;
`endif
    modport master (
        output start, pattern, overlap, bit_in, bit_valid,
        input  busy, match, count, overflow, count_valid
`ifdef SEQ_PAT_MASK_EN
        , output pat_mask
`endif
    );
    modport slave (
        input  start, pattern, overlap, bit_in, bit_valid,
        output busy, match, count, overflow, count_valid
`ifdef SEQ_PAT_MASK_EN
        , input pat_mask
`endif
    );
endinterface

// File: rtl/pattern_window.sv
// pattern_window: shift window, fill counter and (optionally masked) pattern comparator.
// SEQ_PAT_MASK_EN enables the pat_mask don't-care input.
module pattern_window
    import seq_pattern_pkg::*;
#(
    parameter int PAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             clear,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
`ifdef SEQ_PAT_MASK_EN
    input  logic [PAT_W-1:0] pat_mask,
`endif
    output logic             hit
);
    localparam int FW = ctr_w(PAT_W);
    logic [PAT_W-1:0] r_win, r_pat, w_shift, w_mask;
    logic [FW-1:0]    r_fill, w_fill;
    logic             r_ovl;
    assign w_shift = {r_win[PAT_W-2:0], bit_in};
    assign w_fill  = (r_fill == FW'(PAT_W)) ? r_fill : r_fill + 1'b1;
    assign hit     = shift_en && (w_fill == FW'(PAT_W)) && (((w_shift ^ r_pat) & w_mask) == '0);
`ifdef SEQ_PAT_MASK_EN
    logic [PAT_W-1:0] r_mask;
    assign w_mask = r_mask;
    always_ff @(posedge clk) begin
        if (rst)
            r_mask <= '1;
        else if (clear)
            r_mask <= pat_mask;
    end
`else
    assign w_mask = '1;
`endif
    // Non-overlapping mode restarts the fill so a match's bits are never reused.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win  <= '0;
            r_fill <= '0;
            r_pat  <= '0;
            r_ovl  <= MODE_NONOVL;
        end else if (clear) begin
            r_win  <= '0;
            r_fill <= '0;
            r_pat  <= pattern;
            r_ovl  <= overlap;
        end else if (shift_en) begin
            r_win  <= w_shift;
            r_fill <= (hit && r_ovl == MODE_NONOVL) ? '0 : w_fill;
        end
    end
endmodule

// File: rtl/seq_pattern_counter.sv
// seq_pattern_counter: frames a serial stream and counts a programmable bit pattern.
// SEQ_PAT_MASK_EN enables the pat_mask don't-care input.
module seq_pattern_counter
    import seq_pattern_pkg::*;
#(
    parameter int PAT_W     = 3,
    parameter int FRAME_LEN = 32,
    parameter int CNT_W     = 6
) (
    input logic clk,
    input logic rst,
    seq_pattern_counter_if.slave bus
);
    localparam int FC_W = ctr_w(FRAME_LEN);
    logic [1:0]       r_state;
    logic [FC_W-1:0]  r_bits;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf, r_match;
    logic             w_start, w_acc, w_last, w_hit, w_sat;
    assign w_start = (r_state == S_IDLE) && bus.start;
    assign w_acc   = (r_state == S_RUN) && bus.bit_valid;
    assign w_last  = w_acc && (r_bits == FC_W'(FRAME_LEN - 1));
    assign w_sat   = &r_count;
    pattern_window #(.PAT_W(PAT_W)) u_win (
        .clk      (clk),
        .rst      (rst),
        .shift_en (w_acc),
        .clear    (w_start),
        .bit_in   (bus.bit_in),
        .pattern  (bus.pattern),
        .overlap  (bus.overlap),
`ifdef SEQ_PAT_MASK_EN
        .pat_mask (bus.pat_mask),
`endif
        .hit      (w_hit)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_bits  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_match <= 1'b0;
        end else begin
            r_match <= w_hit;
            r_state <= w_start ? S_RUN : w_last ? S_DONE : (r_state == S_DONE) ? S_IDLE : r_state;
            if (w_start) begin
                r_bits  <= '0;
                r_count <= '0;
                r_ovf   <= 1'b0;
            end else if (w_acc) begin
                r_bits <= r_bits + 1'b1;
                if (w_hit) begin
                    r_count <= w_sat ? r_count : r_count + 1'b1;
                    r_ovf   <= r_ovf | w_sat;
                end
            end
        end
    end
    assign bus.busy        = (r_state == S_RUN);
    assign bus.count_valid = (r_state == S_DONE);
    assign bus.match       = r_match;
    assign bus.count       = r_count;
    assign bus.overflow    = r_ovf;
endmodule
